// File: rtl/seq_adder_if.sv
// Request/result bundle for seq_adder: operands and controls in, status and results out.
interface seq_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_adder.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, start/busy/done handshake.
// Define SEQ_ADDER_SAT_EN to clamp the result to the signed range on overflow.
module seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_adder_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc_q;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;

    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b;
    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;
    logic              msb_cin;
    logic              ovf_next;
    logic              last_slice;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  final_sum;

    always_comb begin
        slice_a  = a_q[cnt_q*DIGIT +: DIGIT];
        slice_b  = b_q[cnt_q*DIGIT +: DIGIT];
        {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from its sum bit; only used on the top slice.
        msb_cin  = slice_sum[DIGIT-1] ^ slice_a[DIGIT-1] ^ slice_b[DIGIT-1];
        ovf_next = msb_cin ^ slice_cout;
        acc_next = acc_q;
        acc_next[cnt_q*DIGIT +: DIGIT] = slice_sum;
        last_slice = (cnt_q == CntW'(N - 1));
    end

`ifdef SEQ_ADDER_SAT_EN
    always_comb begin
        final_sum = acc_next;
        if (ovf_next) begin
            final_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign final_sum = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        // Subtraction as a + ~b + ~cin, so the borrow-in inverts the carry.
                        b_q      <= bus.sub ? ~bus.b : bus.b;
                        carry_q  <= bus.cin ^ bus.sub;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_next;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        state    <= StIdle;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= final_sum;
                        bus.cout <= slice_cout;
                        bus.ovf  <= ovf_next;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder (WIDTH=16, DIGIT=4) against an integer-arithmetic model.
module tb_seq_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int          N     = WIDTH / DIGIT;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_adder_if #(.WIDTH(WIDTH)) bus ();

    seq_adder #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {cout, ovf, sum} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int          sa;
        int          sb;
        int          r;
        logic [15:0] s;
        logic        co;
        logic        ov;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            r  = sa - sb - int'(mcin);
            co = (int'(ma) >= int'(mb) + int'(mcin));
            s  = ma - mb - 16'(mcin);
        end else begin
            r  = sa + sb + int'(mcin);
            co = (int'(ma) + int'(mb) + int'(mcin)) > 65535;
            s  = ma + mb + 16'(mcin);
        end
        ov = (r > 32767) || (r < -32768);
`ifdef SEQ_ADDER_SAT_EN
        if (ov) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {co, ov, s};
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns at the same phase, done low.
    task automatic do_op(input string name, input logic [15:0] oa, input logic [15:0] ob,
                         input logic ocin, input logic osub, input logic [15:0] es,
                         input logic ec, input logic eo, input bit noisy);
        int edges;
        bus.start = 1'b1;
        bus.a     = oa;
        bus.b     = ob;
        bus.cin   = ocin;
        bus.sub   = osub;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
        end
        edges = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            if (noisy) begin
                bus.start = 1'($urandom);
                bus.a     = 16'($urandom);
                bus.b     = 16'($urandom);
                bus.cin   = 1'($urandom);
                bus.sub   = 1'($urandom);
            end
            @(posedge clk); #1;
            edges++;
            if (bus.done !== 1'b1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_during_op: got %b want 1 at edge %0d", name, bus.busy,
                             edges);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (edges !== N) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, edges, N);
        end
        checks++;
        if (bus.sum !== es) begin
            errors++;
            $display("FAIL %s sum: got %h want %h", name, bus.sum, es);
        end
        checks++;
        if (bus.cout !== ec) begin
            errors++;
            $display("FAIL %s cout: got %b want %b", name, bus.cout, ec);
        end
        checks++;
        if (bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: got %b want %b", name, bus.ovf, eo);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sum !== es) begin
            errors++;
            $display("FAIL %s after_done: got done=%b sum=%h want done=0 sum=%h", name, bus.done,
                     bus.sum, es);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        do_op("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_ADDER_SAT_EN
        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_random;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic [17:0] exp;
        for (int i = 0; i < 60; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            if (i % 8 == 0) ra = {ra[15], {15{~ra[15]}}};
            exp = model(ra, rb, rc, rs);
            do_op($sformatf("rand%0d", i), ra, rb, rc, rs, exp[15:0], exp[17], exp[16], i[0]);
        end
    endtask

    task automatic test_back_to_back;
        int edges;
        int pulses;
        bus.start = 1'b1;
        bus.a     = 16'd1;
        bus.b     = 16'd1;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 16'd9;
        bus.b     = 16'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        edges = 2;
        while (bus.done !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges !== N || bus.sum !== 16'h0002) begin
            errors++;
            $display("FAIL busy_start_ignored: got edges=%0d sum=%h want edges=%0d sum=0002",
                     edges, bus.sum, N);
        end
        bus.start = 1'b1;
        bus.a     = 16'd3;
        bus.b     = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        while (bus.done !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges !== N + 1 || bus.sum !== 16'h0007) begin
            errors++;
            $display("FAIL start_in_done_cycle: got edges=%0d sum=%h want edges=%0d sum=0007",
                     edges, bus.sum, N + 1);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL no_queued_op: got %0d done pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_op;
        int pulses;
        bus.start = 1'b1;
        bus.a     = 16'h0F0F;
        bus.b     = 16'h1111;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL aborted_op_done: got %0d pulses busy=%b want 0 pulses busy=0", pulses,
                     bus.busy);
        end
        do_op("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_adder.md
# seq_adder

Multi-cycle, parametrised two's-complement adder/subtractor, successor to the fixed 4-bit ripple adder. It processes DIGIT bits per clock through a DIGIT-bit ripple slice, trading latency for area on wide operands. It adds carry-in, subtract mode, signed overflow detection and a start/busy/done handshake, so datapath controllers can issue operations and poll for completion.

## Interface
- WIDTH, 16, operand/result width in bits; must be a positive multiple of DIGIT
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT slices per operation
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on the accepting edge only
- b  input  WIDTH  operand B, sampled on the accepting edge only
- cin  input  1  carry-in, sampled on the accepting edge
- sub  input  1  1 = compute a − b − cin (borrow-in), 0 = a + b + cin
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: sum/cout/ovf freshly valid
- sum  output  WIDTH  result, held until the next done
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed overflow of the final result

## Operation
- One clock, reset synchronous active-low. All state updates on rising clk; rst_n sampled at the edge.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, FSM=IDLE, slice counter=0.
- FSM states:
  - IDLE: busy=0. On start=1, latch a, b' = sub ? ~b : b, carry = cin XOR sub, counter=0 → RUN.
  - RUN: busy=1. Each edge adds slice [counter*DIGIT +: DIGIT] of a and b' with the carry, writes the result slice to an internal accumulator and propagates the carry. On the slice N−1 edge, go to IDLE and load outputs.
- The final edge loads sum from the accumulator, cout from the final carry, and ovf = carry into MSB XOR carry out of MSB. It sets done=1 for exactly one cycle.
- Arithmetic is modulo 2^WIDTH. No reads of a/b/cin/sub occur after the accept edge.
- start while busy=1: ignored, with no queuing and no effect on the current op.
- start in the done cycle (FSM in IDLE): accepted. Back-to-back throughput is one op per N+1 cycles.
- rst_n=0 mid-operation: abort. Outputs go to reset values and done does not pulse for the aborted op.
- DIGIT=WIDTH is legal (N=1).

## Timing
- start sampled high in IDLE at edge k: busy=1 after edge k.
- Slices processed at edges k+1 … k+N.
- After edge k+N: busy=0, done=1, and sum/cout/ovf valid.
- After edge k+N+1: done=0, results held.
- Latency from start to done is N+1 edges (16/4 → 5 edges).
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SEQ_ADDER_SAT_EN defined: on ovf=1 the final sum is clamped. If the latched a[MSB]=0, sum = 0x7F…F (max positive). If a[MSB]=1, sum = 0x80…0 (min negative). ovf still reads 1 and cout is unchanged. Clamping is applied on the final edge, with no extra latency.
- Not defined: sum wraps modulo 2^WIDTH and no clamp logic is synthesised.

## Test plan
All cases use WIDTH=16, DIGIT=4.
- Reset: hold rst_n=0 for 2 cycles → busy=0, done=0, sum=0x0000, cout=0, ovf=0.
- Add a=0x1234, b=0x4321, cin=0, sub=0 at edge k → busy for edges k..k+3. At edge k+4: done=1, sum=0x5555, cout=0, ovf=0. done=0 at k+5.
- Carry chain a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Then sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0.
- Overflow a=0x7FFF, b=0x0001 add → ovf=1, with sum=0x8000 (no macro) or 0x7FFF (SEQ_ADDER_SAT_EN). Then a=0x8000, b=0x0001, sub=1 → ovf=1, with sum=0x7FFF (no macro) or 0x8000 (SEQ_ADDER_SAT_EN).
- Handshake: pulse start with a=1, b=1, then pulse start with a=9, b=9 at edge k+2 (while busy) → single done with sum=0x0002. A new start in the done cycle (a=3, b=4) → second done 5 edges later with sum=0x0007.
- Reset mid-op: start at k, rst_n=0 at k+2 → busy=0 and sum=0 from k+2. No done pulse in the following 10 cycles.
